// File: rtl/vga_render_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_render_multi : VGA timing generator + bird/pipe renderer, per-frame
// bird/pipe collision flag. Build macro VGA_GRID_EN adds a sky grid.
// Revision 1.0
// ============================================================================
module vga_render_multi #(
  parameter int CW         = 10,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int NUM_OBS    = 4,
  parameter int BIRD_SIZE  = 16,
  parameter int OBS_WIDTH  = 50,
  parameter int GAP_HEIGHT = 120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_en,
  input  logic [CW-1:0]         BirdXdraw,
  input  logic [CW-1:0]         BirdYdraw,
  input  logic [NUM_OBS*CW-1:0] X_Edge_flat,
  input  logic [NUM_OBS*CW-1:0] Y_Edge_flat,
  output logic                  vga_h_sync,
  output logic                  vga_v_sync,
  output logic                  vga_r,
  output logic                  vga_g,
  output logic                  vga_b,
  output logic [CW-1:0]         CounterX_out,
  output logic [CW-1:0]         CounterY_out,
  output logic                  frame_start,
  output logic                  collision
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW1     = CW + 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Object extents are one bit wider than the counters so edges past the
  // screen clip instead of wrapping back to the left/top.
  localparam logic [CW:0] BIRD_W = CW1'(BIRD_SIZE);
  localparam logic [CW:0] OBS_W  = CW1'(OBS_WIDTH);
  localparam logic [CW:0] GAP_H  = CW1'(GAP_HEIGHT);

  logic [CW-1:0] x_q, y_q, x_d, y_d;
  logic          hs_q, vs_q, hs_d, vs_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          fs_q, col_q, flag_q;
  logic [CW-1:0] bird_x_q, bird_y_q;
  logic [CW-1:0] obs_x_q [NUM_OBS];
  logic [CW-1:0] obs_y_q [NUM_OBS];

  logic [CW:0]   x_ext, y_ext;
  logic          load_tick, active, bird_hit, pipe_hit;

  always_comb begin
    x_ext     = {1'b0, x_q};
    y_ext     = {1'b0, y_q};
    load_tick = (x_q == '0) && (y_q == V_ACT);
    active    = (x_q < H_ACT) && (y_q < V_ACT);

    x_d = (x_q == H_LAST) ? '0 : x_q + 1'b1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end

    hs_d = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
    vs_d = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));

    bird_hit = (x_ext >= {1'b0, bird_x_q}) && (x_ext < ({1'b0, bird_x_q} + BIRD_W)) &&
               (y_ext >= {1'b0, bird_y_q}) && (y_ext < ({1'b0, bird_y_q} + BIRD_W));

    pipe_hit = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if ((x_ext >= {1'b0, obs_x_q[i]}) && (x_ext < ({1'b0, obs_x_q[i]} + OBS_W)) &&
          !((y_ext >= {1'b0, obs_y_q[i]}) && (y_ext < ({1'b0, obs_y_q[i]} + GAP_H)))) begin
        pipe_hit = 1'b1;
      end
    end

    if (!active) begin
      rgb_d = 3'b000;
    end else if (bird_hit) begin
      rgb_d = 3'b110;
    end else if (pipe_hit) begin
      rgb_d = 3'b010;
    end else begin
`ifdef VGA_GRID_EN
      rgb_d = ((x_q[4:0] == 5'd0) || (y_q[4:0] == 5'd0)) ? 3'b111 : 3'b001;
`else
      rgb_d = 3'b001;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      rgb_q    <= 3'b000;
      fs_q     <= 1'b0;
      col_q    <= 1'b0;
      flag_q   <= 1'b0;
      bird_x_q <= '0;
      bird_y_q <= '0;
      for (int i = 0; i < NUM_OBS; i++) begin
        obs_x_q[i] <= '0;
        obs_y_q[i] <= '0;
      end
    end else if (pix_en) begin
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      fs_q  <= load_tick;
      // Load tick sits in vblank, so the flag can never be set on it.
      if (load_tick) begin
        col_q    <= flag_q;
        flag_q   <= 1'b0;
        bird_x_q <= BirdXdraw;
        bird_y_q <= BirdYdraw;
        for (int i = 0; i < NUM_OBS; i++) begin
          obs_x_q[i] <= X_Edge_flat[i*CW +: CW];
          obs_y_q[i] <= Y_Edge_flat[i*CW +: CW];
        end
      end else if (active && bird_hit && pipe_hit) begin
        flag_q <= 1'b1;
      end
    end
  end

  assign vga_h_sync   = hs_q;
  assign vga_v_sync   = vs_q;
  assign vga_r        = rgb_q[2];
  assign vga_g        = rgb_q[1];
  assign vga_b        = rgb_q[0];
  assign CounterX_out = x_q;
  assign CounterY_out = y_q;
  assign frame_start  = fs_q;
  assign collision    = col_q;

endmodule
`default_nettype wire
